// File: rtl/operate_exec_unit.sv
// ============================================================================
// operate_exec_unit
// ----------------------------------------------------------------------------
// Multi-cycle execute/writeback sequencer for the LC-3 operate instructions
// ADD, AND and NOT. It sits directly beside the register file: it accepts one
// instruction over a valid/ready handshake, drives the two read addresses,
// latches the (combinational) read data, computes the result and writes it
// back through DR/inData/LDREG. It also keeps the NZP condition codes.
//
// Sequence per instruction (one state per cycle):
//   IDLE -> READ -> EXEC -> WB -> IDLE
// The write happens at the edge ending WB, which is the 3rd edge after the
// accept edge. Throughput is one instruction every 4 cycles.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   instr_valid  upstream has an instruction on instr
//   instr        16-bit LC-3 instruction word
//   instr_ready  unit can accept an instruction (state is IDLE)
//   SR1, SR2     register file read addresses (from latched IR)
//   SR1OUT       register file read data for SR1 (combinational)
//   SR2OUT       register file read data for SR2 (combinational)
//   DR           register file write address (from latched IR)
//   inData       register file write data (always the result register)
//   LDREG        register file write enable (high during WB)
//   N, Z, P      condition codes, exactly one is high at all times
//   done         one-cycle pulse after a writeback completes
//   illegal      one-cycle pulse after a non-operate opcode is rejected
//
// Parameters:
//   RESET_NZP    value of {N,Z,P} after reset; must be one-hot
// ============================================================================
module operate_exec_unit #(
    parameter logic [2:0] RESET_NZP = 3'b010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [2:0]  SR1,
    output logic [2:0]  SR2,
    input  logic [15:0] SR1OUT,
    input  logic [15:0] SR2OUT,
    output logic [2:0]  DR,
    output logic [15:0] inData,
    output logic        LDREG,
    output logic        N,
    output logic        Z,
    output logic        P,
    output logic        done,
    output logic        illegal
);

    // LC-3 opcodes handled by this unit
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] ir;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;

    logic [3:0]  opcode;
    logic        op_legal;
    logic [15:0] imm_sext;
    logic [15:0] operand_b;
    logic [15:0] alu_result;
    logic        res_n;
    logic        res_z;
    logic        res_p;

    // Instruction field decode, all taken from the latched IR so that the
    // register file addresses stay stable for the whole instruction.
    assign opcode   = ir[15:12];
    assign op_legal = (opcode == OP_ADD) || (opcode == OP_AND) || (opcode == OP_NOT);
    assign imm_sext = {{11{ir[4]}}, ir[4:0]};

    assign SR1 = ir[8:6];
    assign SR2 = ir[2:0];
    assign DR  = ir[11:9];

    // Second operand: the 5-bit immediate when IR[5] is set, else SR2 data.
    // For NOT this value is latched into B but never used.
    assign operand_b = ir[5] ? imm_sext : SR2OUT;

    // Handshake and write port. LDREG is gated with rst_n so that a reset
    // arriving during WB prevents the register file from capturing at the
    // same edge that clears the sequencer.
    assign instr_ready = (state == IDLE);
    assign LDREG       = (state == WB) & rst_n;
    assign inData      = r;

    // The ALU itself. Only evaluated meaningfully in EXEC, where A and B hold
    // the operands latched in READ; ADD wraps silently at 16 bits.
    always_comb begin
        alu_result = 16'h0000;
        case (opcode)
            OP_ADD:  alu_result = a + b;
            OP_AND:  alu_result = a & b;
            OP_NOT:  alu_result = ~a;
            default: alu_result = 16'h0000;
        endcase
    end

    // Condition codes derived from the result being written back. Because R
    // is either zero, negative or positive, exactly one of these is high.
    always_comb begin
        res_n = r[15];
        res_z = (r == 16'h0000);
        res_p = ~r[15] & ~res_z;
    end

    // Main sequencer. done and illegal default low every cycle so that they
    // only ever form single-cycle pulses in the cycle after WB or READ.
    // Operands are captured in READ, before any write of the same
    // instruction, so DR overlapping SR1/SR2 needs no special handling.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            ir      <= 16'h0000;
            a       <= 16'h0000;
            b       <= 16'h0000;
            r       <= 16'h0000;
            N       <= RESET_NZP[2];
            Z       <= RESET_NZP[1];
            P       <= RESET_NZP[0];
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir    <= instr;
                        state <= READ;
                    end
                end
                READ: begin
                    if (op_legal) begin
                        a     <= SR1OUT;
                        b     <= operand_b;
                        state <= EXEC;
                    end else begin
                        illegal <= 1'b1;
                        state   <= IDLE;
                    end
                end
                EXEC: begin
                    r     <= alu_result;
                    state <= WB;
                end
                WB: begin
                    N     <= res_n;
                    Z     <= res_z;
                    P     <= res_p;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/operate_exec_unit.md
Name: operate_exec_unit

Overview:
- Multi-cycle execute/writeback sequencer for LC-3 operate instructions: ADD, AND, NOT.
- Accepts one instruction over a valid/ready handshake and drives the register file read addresses (SR1/SR2).
- Latches the asynchronous read data, computes the result, and writes it back through DR/inData/LDREG.
- Maintains the NZP condition-code register; sits directly beside the register file in the datapath.

Parameters:
- RESET_NZP, 3'b010, value of {N,Z,P} after reset; must be one-hot.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- instr_valid  input  1  upstream has an instruction on instr.
- instr  input  16  LC-3 instruction word.
- instr_ready  output  1  unit can accept an instruction.
- SR1  output  3  register file read address 1.
- SR2  output  3  register file read address 2.
- SR1OUT  input  16  register file read data 1 (combinational from SR1).
- SR2OUT  input  16  register file read data 2 (combinational from SR2).
- DR  output  3  register file write address.
- inData  output  16  register file write data.
- LDREG  output  1  register file write enable.
- N, Z, P  output  1 each  condition codes.
- done  output  1  one-cycle pulse when writeback completes.
- illegal  output  1  one-cycle pulse when a non-operate opcode is rejected.

Behaviour:
- States: IDLE, READ, EXEC, WB.
- Reset (rst_n=0 at an edge):
  - State goes to IDLE; IR, A, B, R clear to 0.
  - {N,Z,P} = RESET_NZP; done = illegal = 0.
  - Any in-flight instruction is discarded with no write.
- LDREG = (state==WB) & rst_n, combinational, so a reset asserted during WB suppresses the write at that edge.
- instr_ready = (state==IDLE).
- IDLE:
  - On an edge with instr_valid & instr_ready: IR <= instr, go to READ.
  - Otherwise stay in IDLE; instr is ignored.
- Address outputs:
  - SR1 = IR[8:6], SR2 = IR[2:0], DR = IR[11:9], all from the latched IR.
  - All read 0 after reset.
- READ: opcode = IR[15:12].
  - 0001, 0101, 1001: A <= SR1OUT, B <= (IR[5] ? sign-extend IR[4:0] to 16 bits : SR2OUT); go to EXEC.
  - Any other opcode: pulse illegal in the following cycle, go to IDLE; no write, NZP unchanged.
- EXEC:
  - ADD: R <= A + B mod 2^16.
  - AND: R <= A & B.
  - NOT: R <= ~A; IR[5:0] and B are ignored.
  - Go to WB.
- WB:
  - inData = R, LDREG = 1; the register file captures at the end of this cycle.
  - At the same edge: N <= R[15]; Z <= (R==0); P <= ~R[15] & (R!=0).
  - Exactly one of N, Z, P is high at all times.
  - done pulses in the cycle after WB; go to IDLE.
- inData holds R in every state and equals 0 after reset.
- Latency: accept edge -> READ -> EXEC -> WB. The write edge is the 3rd edge after the accept edge.
- Throughput: one instruction per 4 cycles; instr_ready returns the cycle after WB.
- Hazards: DR may equal SR1/SR2. Operands are latched in READ before the write, so no hazard exists within the unit.
- instr_valid held high continuously: a new instruction is taken on each IDLE edge. There is no combinational ready-to-valid path.
- Overflow: ADD wraps silently; no flag.

Test Plan:
- Reset with rst_n=0 for 2 cycles -> instr_ready=1, LDREG=0, {N,Z,P}=010, SR1=SR2=DR=0, done=0.
- R2=0x0005, R3=0x0007; ADD R1,R2,R3 (0x1283) -> LDREG=1 exactly 3 edges after accept with DR=1, inData=0x000C; {N,Z,P}=001; done pulses once.
- R2=0x0001; ADD R4,R2,#-3 (0x18BD) -> inData=0xFFFE, {N,Z,P}=100. Then AND R5,R4,#0 (0x5B20) -> inData=0x0000, {N,Z,P}=010.
- R6=0xFFFF; NOT R7,R6 (0x9FBF) -> inData=0x0000, DR=7, Z=1.
- Opcode 0x0000 (BR) -> illegal pulses once, LDREG never asserted, NZP unchanged, instr_ready=1 two cycles after accept.
- Reset during EXEC and during WB of ADD R1,R2,R3 -> no LDREG high at the reset edge, R1 unchanged, state IDLE, NZP=RESET_NZP.
- Back-to-back: instr_valid held high with two ADDs -> second accepted exactly 4 cycles after the first; both writes are correct.
